// File: rtl/clock_divider_pkg.sv
// Shared mode encodings and reset defaults for the clock divider bank.
// CLOCK_DIVIDER_STEP_EN decides whether mode 2 (STEP) is executable or folds onto TOGGLE.
package clock_divider_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'd0,
    MODE_PULSE  = 2'd1,
    MODE_STEP   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam int unsigned DEFAULT_DIV = 25000000;

  // Map a raw mode field onto a mode this build can execute.
  function automatic mode_e norm_mode(input logic [1:0] raw);
    case (raw)
      MODE_PULSE: return MODE_PULSE;
`ifdef CLOCK_DIVIDER_STEP_EN
      MODE_STEP:  return MODE_STEP;
`endif
      default:    return MODE_TOGGLE;
    endcase
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, pending config, mode output logic, optional step edge-detect.
// Step logic is built only when CLOCK_DIVIDER_STEP_EN is defined.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 32,
  parameter int unsigned RESET_DIV = clock_divider_pkg::DEFAULT_DIV
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 cfg_we_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [1:0]           cfg_mode_i,
  input  logic                 step_req_i,
  output logic                 clk_out_o,
  output logic                 tick_o,
  output logic                 cfg_pending_o
);

  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0] div_act_q, div_act_d;
  logic [DIV_WIDTH-1:0] div_pend_q, div_pend_d;
  mode_e                mode_act_q, mode_act_d;
  mode_e                mode_pend_q, mode_pend_d;
  logic                 pend_q, pend_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;

  logic                 step_mode, terminal, load_now, load, step_edge;
  logic [DIV_WIDTH-1:0] new_div;
  mode_e                new_mode;

`ifdef CLOCK_DIVIDER_STEP_EN
  logic step_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_req_i;
    end
  end

  assign step_edge = step_req_i & ~step_q;
`else
  logic unused_step_req;
  assign unused_step_req = step_req_i;
  assign step_edge       = 1'b0;
`endif

  assign step_mode = (mode_act_q == MODE_STEP);
  assign terminal  = enable_i && !step_mode && (count_q == div_act_q);
  // STEP has no terminal count, so a write there takes effect at once.
  assign load_now  = cfg_we_i && (terminal || step_mode);
  assign load      = load_now || (terminal && pend_q);
  assign new_div   = load_now ? cfg_div_i : div_pend_q;
  assign new_mode  = load_now ? norm_mode(cfg_mode_i) : mode_pend_q;

  always_comb begin
    count_d     = count_q;
    div_act_d   = div_act_q;
    mode_act_d  = mode_act_q;
    div_pend_d  = div_pend_q;
    mode_pend_d = mode_pend_q;
    pend_d      = pend_q;
    clk_d       = clk_q;
    tick_d      = 1'b0;

    case (mode_act_q)
      MODE_PULSE: begin
        clk_d  = 1'b0;
        tick_d = terminal;
      end
      MODE_STEP: begin
        clk_d  = clk_q ^ step_edge;
        tick_d = step_edge;
      end
      default: clk_d = clk_q ^ terminal;
    endcase

    if (enable_i && !step_mode) begin
      count_d = terminal ? '0 : count_q + DIV_WIDTH'(1);
    end

    if (cfg_we_i && !load_now) begin
      div_pend_d  = cfg_div_i;
      mode_pend_d = norm_mode(cfg_mode_i);
      pend_d      = 1'b1;
    end

    if (load) begin
      div_act_d  = new_div;
      mode_act_d = new_mode;
      pend_d     = 1'b0;
      if (new_mode == MODE_PULSE) clk_d = 1'b0;
      if (new_mode == MODE_STEP)  count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q     <= '0;
      div_act_q   <= DIV_WIDTH'(RESET_DIV);
      mode_act_q  <= MODE_TOGGLE;
      div_pend_q  <= '0;
      mode_pend_q <= MODE_TOGGLE;
      pend_q      <= 1'b0;
      clk_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      div_act_q   <= div_act_d;
      mode_act_q  <= mode_act_d;
      div_pend_q  <= div_pend_d;
      mode_pend_q <= mode_pend_d;
      pend_q      <= pend_d;
      clk_q       <= clk_d;
      tick_q      <= tick_d;
    end
  end

  assign clk_out_o     = clk_q;
  assign tick_o        = tick_q;
  assign cfg_pending_o = pend_q;

endmodule

// File: rtl/clock_divider_bank.sv
// N_CH independent run-time reprogrammable clock dividers sharing one config write port.
// Define CLOCK_DIVIDER_STEP_EN to enable manual single-step mode.
module clock_divider_bank #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned DIV_WIDTH   = 32,
  parameter int unsigned DEFAULT_DIV = clock_divider_pkg::DEFAULT_DIV,
  parameter int unsigned SEL_WIDTH   = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_CH-1:0]      ch_enable_i,
  input  logic                 cfg_we_i,
  input  logic [SEL_WIDTH-1:0] cfg_sel_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [1:0]           cfg_mode_i,
  input  logic [N_CH-1:0]      step_req_i,
  output logic [N_CH-1:0]      clk_out_o,
  output logic [N_CH-1:0]      tick_o,
  output logic [N_CH-1:0]      cfg_pending_o
);

  logic [N_CH-1:0] cfg_we_ch;

  // Selects at or beyond N_CH match no channel, so such writes vanish.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign cfg_we_ch[i] = cfg_we_i && (cfg_sel_i == SEL_WIDTH'(i));

    clock_divider_channel #(
      .DIV_WIDTH (DIV_WIDTH),
      .RESET_DIV (DEFAULT_DIV)
    ) u_channel (
      .clock         (clock),
      .reset         (reset),
      .enable_i      (ch_enable_i[i]),
      .cfg_we_i      (cfg_we_ch[i]),
      .cfg_div_i     (cfg_div_i),
      .cfg_mode_i    (cfg_mode_i),
      .step_req_i    (step_req_i[i]),
      .clk_out_o     (clk_out_o[i]),
      .tick_o        (tick_o[i]),
      .cfg_pending_o (cfg_pending_o[i])
    );
  end

endmodule
